// File: rtl/ram_sdp_clr.sv
// ram_sdp_clr: simple-dual-port synchronous RAM (one write port, one read
// port) with a built-in clear sweep that initialises every word to
// CLEAR_VALUE after reset or on request. Read latency is 1 or 2 edges,
// same-address write/read collisions are write-first, and every output
// is registered.
//
// Read handshake: there is no back-pressure. rd_en is accepted on any
// edge where the block is READY and clear is low; each accepted read
// produces exactly one data_valid pulse, READ_LATENCY-1 edges later, and
// data_out holds its last value between pulses.
module ram_sdp_clr #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    RAM_DEPTH    = 1 << ADDR_WIDTH,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    output logic                  busy,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_address,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  dbg_state_o
);

    typedef enum logic {
        ST_READY = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0]   mem_q [RAM_DEPTH];

    logic                    wr_in_range;
    logic                    rd_in_range;
    logic                    wr_do;
    logic [ADDR_WIDTH-1:0]   wr_addr_m;
    logic [DATA_WIDTH-1:0]   wr_data_m;
    logic                    rd_do;
    logic [ADDR_WIDTH-1:0]   rd_idx;
    logic [DATA_WIDTH-1:0]   rd_word;

    logic [DATA_WIDTH-1:0]   data_out_q;
    logic                    data_valid_q;

    assign wr_in_range = ({1'b0, wr_address} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, rd_address} < DEPTH_EXT);

    // Sequencer: sweep the clear counter in CLEAR, arbitrate the user ports in READY.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_do     = 1'b0;
        wr_addr_m = wr_address;
        wr_data_m = data_in;
        rd_do     = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                // User ports are ignored while sweeping; clear cannot restart it.
                wr_do     = 1'b1;
                wr_addr_m = cnt_q;
                wr_data_m = CLEAR_VALUE;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (clear) begin
                    // clear wins over a same-edge write or read.
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else begin
                    wr_do = wr_en && wr_in_range;
                    rd_do = rd_en;
                end
            end
        endcase
    end

    // Sequencer state and sweep counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage array; not reset, the sweep initialises it.
    always_ff @(posedge clk) begin
        if (wr_do) begin
            mem_q[wr_addr_m] <= wr_data_m;
        end
    end

    // Read word: write-first bypass on collision, CLEAR_VALUE beyond the depth.
    always_comb begin
        rd_idx  = rd_in_range ? rd_address : '0;
        rd_word = CLEAR_VALUE;
        if (wr_do && (wr_address == rd_address)) begin
            rd_word = data_in;
        end else if (rd_in_range) begin
            rd_word = mem_q[rd_idx];
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] s1_data_q;
            logic                  s1_valid_q;

            // Two-stage read pipeline; stage 2 drains regardless of clear.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_data_q    <= '0;
                    s1_valid_q   <= 1'b0;
                    data_out_q   <= '0;
                    data_valid_q <= 1'b0;
                end else begin
                    s1_valid_q   <= rd_do;
                    if (rd_do) begin
                        s1_data_q <= rd_word;
                    end
                    data_valid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        data_out_q <= s1_data_q;
                    end
                end
            end
        end else begin : g_lat1
            // Single-stage read: result registered on the accepting edge.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_out_q   <= '0;
                    data_valid_q <= 1'b0;
                end else begin
                    data_valid_q <= rd_do;
                    if (rd_do) begin
                        data_out_q <= rd_word;
                    end
                end
            end
        end
    endgenerate

    assign busy        = (state_q == ST_CLEAR);
    assign dbg_state_o = state_q;
    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;

endmodule
